// File: rtl/onchip_mem_stream_reader.sv
// Block reader: streams word_count words from a single-port on-chip memory
// (fixed read latency 1) into a small output FIFO exposed as a valid/ready source.
module onchip_mem_stream_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [1:0]        dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // Stream handshake: a word transfers in every cycle where st_valid and st_ready are both high.
    logic              rst_sync_q;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic        accept, issue, kill, push, pop;
    logic [CW:0] credit;

    always_comb begin
        accept = start && rst_sync_q && (state_q == IDLE);
        kill   = abort && (state_q != IDLE);
        // Space is credited to the read still in flight, so a pop is never needed to absorb it.
        credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue  = (state_q == RUN) && !abort && (credit < DEPTH_C);
        push   = inflight_q && !kill;
        pop    = st_valid && st_ready && !kill;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        inflight_d = issue;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (word_count != '0) begin
                        state_d  = RUN;
                        addr_d   = base_addr;
                        remain_d = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!inflight_q && count_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Release is synchronised; the first start is taken on the second edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= m_readdata;
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign m_address    = addr_q;
    assign m_chipselect = issue;
    assign m_write      = 1'b0;
    assign m_byteenable = 4'hF;
    assign m_writedata  = '0;
    assign m_clken      = 1'b1;
    assign st_valid     = (count_q != '0);
    assign st_data      = fifo_mem[rd_ptr_q];
    assign dbg_state    = state_q;
endmodule
